cache_ctrl_4way: RTL and testbench

CACHE_CTRL_4WAY -- requirements
Module: cache_ctrl_4way

---
 rtl/cache_ctrl_4way.sv | 129 ++++++++++++
 tb/tb_cache_ctrl_4way.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_4way.sv
// cache_ctrl_4way: 4-way set-associative cache controller FSM; define CACHE_CTRL_STATS_EN for hit/miss counters
module cache_ctrl_4way #(
  parameter int TAG_W = 19,
  parameter int INDEX_W = 7,
  parameter int OFFSET_W = 6,
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CACHE_CTRL_STATS_EN
  output logic [31:0]          stat_hits_o,
  output logic [31:0]          stat_misses_o,
`endif
  input  logic                 cpu_req_valid_i,
  output logic                 cpu_req_ready_o,
  input  logic                 cpu_req_we_i,
  input  logic [ADDR_W-1:0]    cpu_req_addr_i,
  output logic                 cpu_resp_valid_o,
  output logic                 cpu_resp_hit_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_req_we_o,
  output logic [ADDR_W-1:0]    mem_req_addr_o,
  input  logic                 mem_resp_valid_i,
  output logic                 ta_rst_o,
  output logic [INDEX_W-1:0]   ta_index_o,
  output logic [TAG_W-1:0]     ta_tag_in_o,
  output logic                 ta_valid_in_o,
  output logic                 ta_dirty_in_o,
  output logic                 ta_write_en_o,
  output logic [1:0]           ta_write_way_o,
  output logic                 ta_update_lru_o,
  output logic [1:0]           ta_accessed_way_o,
  input  logic [4*TAG_W-1:0]   ta_tag_out_i,
  input  logic [3:0]           ta_valid_out_i,
  input  logic [3:0]           ta_dirty_out_i,
  input  logic                 ta_hit_i,
  input  logic [1:0]           ta_hit_way_i,
  input  logic [1:0]           ta_lru_way_i
);
  typedef enum logic [3:0] {INIT, IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, UPDATE, RESPOND} state_e;
  state_e state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d, req_idx_q, idx_d, ta_index_q;
  logic [TAG_W-1:0] req_tag_q, vtag_q, vtag_d, vtag;
  logic [1:0] vway_q, vway_d, vway;
  logic we_q, accept, vdirty, lk_hit, upd;
  logic ready_q, resp_valid_q, resp_hit_q, mem_valid_q, mem_we_q, ta_rst_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic unused_offset;
  assign unused_offset = ^cpu_req_addr_i[OFFSET_W-1:0];
  assign accept = state_q == IDLE && cpu_req_valid_i && !rst;
  assign vway = !ta_valid_out_i[0] ? 2'd0 : !ta_valid_out_i[1] ? 2'd1 :
                !ta_valid_out_i[2] ? 2'd2 : !ta_valid_out_i[3] ? 2'd3 : ta_lru_way_i;
  assign vtag = ta_tag_out_i[int'(vway)*TAG_W +: TAG_W];
  assign vdirty = ta_valid_out_i[vway] && ta_dirty_out_i[vway];
  assign cnt_d = (rst || state_q != INIT) ? '0 : cnt_q + INDEX_W'(1);
  assign idx_d = accept ? cpu_req_addr_i[OFFSET_W +: INDEX_W] : req_idx_q;
  assign vtag_d = state_q == LOOKUP ? vtag : vtag_q;
  assign vway_d = state_q == LOOKUP ? vway : vway_q;
  // next-state selection; reset overrides everything and restarts the tag sweep
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = cnt_q == '1 ? IDLE : INIT;
      IDLE:    state_d = cpu_req_valid_i ? LOOKUP : IDLE;
      LOOKUP:  state_d = ta_hit_i ? RESPOND : vdirty ? WB_REQ : RF_REQ;
      WB_REQ:  state_d = mem_req_ready_i ? WB_WAIT : WB_REQ;
      WB_WAIT: state_d = mem_resp_valid_i ? RF_REQ : WB_WAIT;
      RF_REQ:  state_d = mem_req_ready_i ? RF_WAIT : RF_REQ;
      RF_WAIT: state_d = mem_resp_valid_i ? UPDATE : RF_WAIT;
      UPDATE:  state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = INIT;
    endcase
    if (rst) state_d = INIT;
  end
  // state, request/victim capture, and outputs registered from the next state
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    req_idx_q <= idx_d;
    vtag_q <= vtag_d;
    vway_q <= vway_d;
    if (accept) begin
      req_tag_q <= cpu_req_addr_i[OFFSET_W+INDEX_W +: TAG_W];
      we_q <= cpu_req_we_i;
    end
    ta_rst_q <= state_d == INIT;
    ta_index_q <= state_d == INIT ? cnt_d : idx_d;
    ready_q <= state_d == IDLE;
    resp_valid_q <= state_d == RESPOND;
    resp_hit_q <= state_d == RESPOND && state_q == LOOKUP;
    mem_valid_q <= state_d == WB_REQ || state_d == RF_REQ;
    mem_we_q <= state_d == WB_REQ;
    mem_addr_q <= {state_d == WB_REQ ? vtag_d : req_tag_q, idx_d, {OFFSET_W{1'b0}}};
  end
  assign cpu_req_ready_o = ready_q;
  assign cpu_resp_valid_o = resp_valid_q;
  assign cpu_resp_hit_o = resp_hit_q;
  assign mem_req_valid_o = mem_valid_q;
  assign mem_req_we_o = mem_we_q;
  assign mem_req_addr_o = mem_addr_q;
  assign ta_rst_o = ta_rst_q;
  assign ta_index_o = ta_index_q;
  assign lk_hit = state_q == LOOKUP && ta_hit_i;
  assign upd = state_q == UPDATE;
  assign ta_write_en_o = (lk_hit && we_q) || upd;
  assign ta_write_way_o = upd ? vway_q : ta_hit_way_i;
  assign ta_tag_in_o = req_tag_q;
  assign ta_valid_in_o = ta_write_en_o;
  assign ta_dirty_in_o = ta_write_en_o && we_q;
  assign ta_update_lru_o = lk_hit || upd;
  assign ta_accessed_way_o = ta_write_way_o;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hits_q, misses_q;
  // saturating hit/miss counters sampled on each completion cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q <= '0;
      misses_q <= '0;
    end else if (state_q == RESPOND) begin
      if (resp_hit_q && hits_q != '1) hits_q <= hits_q + 32'd1;
      if (!resp_hit_q && misses_q != '1) misses_q <= misses_q + 32'd1;
    end
  end
  assign stat_hits_o = hits_q;
  assign stat_misses_o = misses_q;
`endif
endmodule

// File: tb/tb_cache_ctrl_4way.sv
// tb_cache_ctrl_4way: directed self-checking bench for cache_ctrl_4way
module tb_cache_ctrl_4way;
  logic clk = 0, rst = 1;
  logic cpu_req_valid = 0, cpu_req_ready, cpu_req_we = 0;
  logic [31:0] cpu_req_addr = 0;
  logic cpu_resp_valid, cpu_resp_hit;
  logic mem_req_valid, mem_req_ready = 0, mem_req_we;
  logic [31:0] mem_req_addr;
  logic mem_resp_valid = 0;
  logic ta_rst, ta_valid_in, ta_dirty_in, ta_write_en, ta_update_lru;
  logic [6:0] ta_index;
  logic [18:0] ta_tag_in;
  logic [1:0] ta_write_way, ta_accessed_way;
  logic [75:0] ta_tag_out = 0;
  logic [3:0] ta_valid_out = 0, ta_dirty_out = 0;
  logic ta_hit = 0;
  logic [1:0] ta_hit_way = 0, ta_lru_way = 0;
  int checks = 0, failures = 0;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  cache_ctrl_4way dut (
    .clk(clk), .rst(rst),
`ifdef CACHE_CTRL_STATS_EN
    .stat_hits_o(stat_hits), .stat_misses_o(stat_misses),
`endif
    .cpu_req_valid_i(cpu_req_valid), .cpu_req_ready_o(cpu_req_ready),
    .cpu_req_we_i(cpu_req_we), .cpu_req_addr_i(cpu_req_addr),
    .cpu_resp_valid_o(cpu_resp_valid), .cpu_resp_hit_o(cpu_resp_hit),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_we_o(mem_req_we), .mem_req_addr_o(mem_req_addr),
    .mem_resp_valid_i(mem_resp_valid),
    .ta_rst_o(ta_rst), .ta_index_o(ta_index), .ta_tag_in_o(ta_tag_in),
    .ta_valid_in_o(ta_valid_in), .ta_dirty_in_o(ta_dirty_in),
    .ta_write_en_o(ta_write_en), .ta_write_way_o(ta_write_way),
    .ta_update_lru_o(ta_update_lru), .ta_accessed_way_o(ta_accessed_way),
    .ta_tag_out_i(ta_tag_out), .ta_valid_out_i(ta_valid_out),
    .ta_dirty_out_i(ta_dirty_out), .ta_hit_i(ta_hit),
    .ta_hit_way_i(ta_hit_way), .ta_lru_way_i(ta_lru_way)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // present a request in IDLE; returns at the negedge of the LOOKUP cycle
  task automatic issue(input logic we, input logic [31:0] a);
    cpu_req_valid = 1;
    cpu_req_we = we;
    cpu_req_addr = a;
    cyc();
    cpu_req_valid = 0;
    chk("lookup_ready", cpu_req_ready, 0);
    chk("lookup_index", ta_index, a[12:6]);
  endtask

  // called at the negedge of an RF_REQ cycle; walks refill, update and response
  task automatic finish_refill(input logic [31:0] a, input logic [1:0] w, input logic [18:0] tag, input logic d);
    chk("rf_valid", mem_req_valid, 1);
    chk("rf_we", mem_req_we, 0);
    chk("rf_addr", mem_req_addr, {a[31:6], 6'b0});
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0;
    chk("rfw_valid", mem_req_valid, 0);
    mem_resp_valid = 1;
    cyc();
    mem_resp_valid = 0;
    chk("upd_wen", ta_write_en, 1);
    chk("upd_way", ta_write_way, w);
    chk("upd_tag", ta_tag_in, tag);
    chk("upd_valid", ta_valid_in, 1);
    chk("upd_dirty", ta_dirty_in, d);
    chk("upd_lru", ta_update_lru, 1);
    chk("upd_acc", ta_accessed_way, w);
    chk("upd_resp", cpu_resp_valid, 0);
    cyc();
    chk("miss_resp_valid", cpu_resp_valid, 1);
    chk("miss_resp_hit", cpu_resp_hit, 0);
    chk("miss_resp_wen", ta_write_en, 0);
    cyc();
    chk("miss_idle_ready", cpu_req_ready, 1);
    chk("miss_idle_resp", cpu_resp_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) cyc();
    chk("rst_ready", cpu_req_ready, 0);
    chk("rst_index", ta_index, 0);
    chk("rst_memv", mem_req_valid, 0);
    chk("rst_respv", cpu_resp_valid, 0);
    chk("rst_wen", ta_write_en, 0);
    rst = 0;
    for (int i = 0; i < 128; i++) begin
      chk("init_index", ta_index, i);
      chk("init_tarst", ta_rst, 1);
      chk("init_ready", cpu_req_ready, 0);
      cyc();
    end
    chk("init_done_ready", cpu_req_ready, 1);
    chk("init_done_tarst", ta_rst, 0);
    mem_resp_valid = 1;
    cyc();
    mem_resp_valid = 0;
    chk("idle_stray_resp", cpu_req_ready, 1);
    // read miss into an empty set: lowest invalid way 0 wins over lru 3
    ta_lru_way = 3;
    issue(0, 32'h0001_2340);
    chk("miss_lookup_lru", ta_update_lru, 0);
    chk("miss_lookup_wen", ta_write_en, 0);
    cyc();
    chk("rf_hold_valid", mem_req_valid, 1);
    cyc();
    finish_refill(32'h0001_2340, 0, 19'h9, 0);
    // repeat read hits way 0
    ta_hit = 1;
    ta_hit_way = 0;
    ta_valid_out = 4'b0001;
    issue(0, 32'h0001_2340);
    chk("hit_lru", ta_update_lru, 1);
    chk("hit_acc", ta_accessed_way, 0);
    chk("hit_wen", ta_write_en, 0);
    chk("hit_memv", mem_req_valid, 0);
    chk("hit_resp_early", cpu_resp_valid, 0);
    cyc();
    chk("hit_resp_valid", cpu_resp_valid, 1);
    chk("hit_resp_hit", cpu_resp_hit, 1);
    chk("hit_resp_memv", mem_req_valid, 0);
    cyc();
    chk("hit_idle_resp", cpu_resp_valid, 0);
`ifdef CACHE_CTRL_STATS_EN
    chk("stat_hits", stat_hits, 1);
    chk("stat_misses", stat_misses, 1);
`endif
    // write hit way 3 marks the line dirty
    ta_hit_way = 3;
    issue(1, 32'h0001_2340);
    chk("whit_wen", ta_write_en, 1);
    chk("whit_way", ta_write_way, 3);
    chk("whit_tag", ta_tag_in, 19'h9);
    chk("whit_valid", ta_valid_in, 1);
    chk("whit_dirty", ta_dirty_in, 1);
    chk("whit_acc", ta_accessed_way, 3);
    cyc();
    chk("whit_resp_hit", cpu_resp_hit, 1);
    cyc();
    // full dirty set 0x0D, lru way 2: write back then refill
    ta_hit = 0;
    ta_valid_out = 4'hF;
    ta_dirty_out = 4'hF;
    ta_lru_way = 2;
    ta_tag_out = {19'h11111, 19'h5A5A5, 19'h22222, 19'h33333};
    issue(0, 32'h0000_E340);
    cyc();
    ta_tag_out = 0;
    for (int i = 0; i < 5; i++) begin
      chk("wb_valid", mem_req_valid, 1);
      chk("wb_we", mem_req_we, 1);
      chk("wb_addr", mem_req_addr, 32'hB4B4_A340);
      cyc();
    end
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0;
    chk("wbw_valid", mem_req_valid, 0);
    mem_resp_valid = 1;
    cyc();
    mem_resp_valid = 0;
    finish_refill(32'h0000_E340, 2, 19'h7, 0);
    // invalid way 3 preferred over lru even though others dirty: no write-back
    ta_valid_out = 4'b0111;
    ta_lru_way = 0;
    issue(1, 32'h0000_6340);
    cyc();
    finish_refill(32'h0000_6340, 3, 19'h3, 1);
    // reset in the middle of a write-back wait
    ta_valid_out = 4'hF;
    ta_lru_way = 1;
    ta_tag_out = {19'h11111, 19'h5A5A5, 19'h22222, 19'h33333};
    issue(0, 32'h0000_E340);
    cyc();
    chk("wb2_addr", mem_req_addr, 32'h4444_4340);
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0;
    cyc();
    chk("wb2_wait_valid", mem_req_valid, 0);
    rst = 1;
    cyc();
    chk("mid_rst_tarst", ta_rst, 1);
    chk("mid_rst_index", ta_index, 0);
    chk("mid_rst_ready", cpu_req_ready, 0);
    chk("mid_rst_memv", mem_req_valid, 0);
    rst = 0;
    mem_resp_valid = 1;
    cyc();
    mem_resp_valid = 0;
    chk("late_resp_index", ta_index, 1);
    chk("late_resp_memv", mem_req_valid, 0);
    chk("late_resp_tarst", ta_rst, 1);
    n = 0;
    while (!cpu_req_ready && n < 200) begin
      cyc();
      n++;
    end
    chk("resweep_cycles", n, 127);
    chk("resweep_memv", mem_req_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
